hvac_sequencer: RTL and testbench
=================================

HVAC_SEQUENCER -- requirements
Module: hvac_sequencer

Interface
REQ-001 The block SHALL have parameter FAN_LEAD, default 4: fan-only cycles before an actuator turns on; legal range 1..65535.
REQ-002 The block SHALL have parameter MIN_ON, default 16: minimum actuator-on cycles; legal range 1..65535.
REQ-003 The block SHALL have parameter MIN_OFF, default 32: lockout cycles after an actuator turns off; legal range 1..65535.
REQ-004 The block SHALL have parameter FAN_PURGE, default 8: fan-only cycles after an actuator turns off; legal range 1..65535.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port enable, input, 1 bit: system enable; low forbids starting a run and ends any run in progress.
REQ-008 The block SHALL have port heater_on, input, 1 bit: heat request from the temperature controller.
REQ-009 The block SHALL have port ac_on, input, 1 bit: cool request from the temperature controller.
REQ-010 The block SHALL have port heater_en, output, 1 bit: heater actuator drive.
REQ-011 The block SHALL have port ac_en, output, 1 bit: AC compressor drive.
REQ-012 The block SHALL have port fan_en, output, 1 bit: blower drive.
REQ-013 The block SHALL have port lockout, output, 1 bit: high while in HOLD.
REQ-014 The block SHALL have port req_conflict, output, 1 bit: sticky flag, set when heater_on and ac_on are sampled high together.
REQ-015 The block SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-016 The FSM SHALL have states IDLE=0, LEAD=1, HEAT=2, COOL=3, PURGE=4 and HOLD=5.
REQ-017 The block SHALL define heat_req = heater_on & ~ac_on and cool_req = ac_on & ~heater_on; both inputs high SHALL count as no request.
REQ-018 All outputs SHALL be registered and decoded from the state register (Moore), with no combinational input-to-output path.
REQ-019 In IDLE, if enable & (heat_req | cool_req) is sampled at an edge, the FSM SHALL enter LEAD at that edge, latch the mode (heat or cool), and load the 16-bit down-counter with FAN_LEAD-1.
REQ-020 In LEAD, fan_en SHALL be 1 and both actuators SHALL be 0.
REQ-021 In LEAD, if the latched request drops or enable is low, the FSM SHALL return to IDLE without driving either actuator and without lockout.
REQ-022 In LEAD, when the counter reads 0, the FSM SHALL enter HEAT or COOL per the latched mode and load MIN_ON-1.
REQ-023 In HEAT, heater_en and fan_en SHALL be 1; in COOL, ac_en and fan_en SHALL be 1; heater_en and ac_en SHALL never be 1 together.
REQ-024 HEAT/COOL SHALL exit only when the counter is 0 and the latched request is deasserted; an opposite-mode request SHALL count as deasserted.
REQ-025 enable low in HEAT/COOL SHALL exit at that edge regardless of the counter.
REQ-026 The HEAT/COOL exit target SHALL be PURGE, loading FAN_PURGE-1 (see REQ-034).
REQ-027 In PURGE, only fan_en SHALL be 1; at counter 0 the FSM SHALL enter HOLD and load MIN_OFF-1.
REQ-028 In HOLD, all drives SHALL be 0 and lockout SHALL be 1; requests SHALL be ignored; at counter 0 the FSM SHALL enter IDLE.
REQ-029 The counter SHALL decrement by 1 per cycle in LEAD, HEAT, COOL, PURGE and HOLD, SHALL saturate at 0, and SHALL never wrap.
REQ-030 The latched mode SHALL be fixed from LEAD until IDLE is re-entered; a mode change therefore SHALL always pass through PURGE and HOLD.
REQ-031 req_conflict SHALL be set one cycle after heater_on & ac_on is sampled high, and SHALL clear only on rst.

Reset
REQ-032 On rst high at a rising edge: the FSM SHALL go to IDLE, the counter and latched mode SHALL clear to 0, and heater_en, ac_en, fan_en, lockout and req_conflict SHALL all be 0 after that edge, including mid-run.
REQ-033 rst SHALL take priority over every other input.

Configuration
REQ-034 Macro HVAC_FAN_PURGE_EN: when defined, PURGE SHALL exist as specified; when undefined, HEAT/COOL SHALL exit directly to HOLD (loading MIN_OFF-1), FAN_PURGE SHALL be unused, and state 4 SHALL be unreachable.

Verification
REQ-035 Heat request held from IDLE (defaults, macro defined) -> fan_en high after edge N, heater_en high after edge N+4; with the request dropped at N+6, heater_en stays high until N+20, then 8 PURGE cycles, then 32 lockout cycles, then IDLE.
REQ-036 Heat request pulsed for 2 cycles -> LEAD aborts to IDLE at the next edge; heater_en never asserts; lockout stays 0.
REQ-037 COOL active, inputs switched to heat at MIN_ON/2 -> ac_en held until MIN_ON elapses, then PURGE and HOLD, then LEAD in heat mode; heater_en and ac_en never overlap.
REQ-038 heater_on and ac_on high together from IDLE -> no run starts; req_conflict goes high one cycle later and stays high until rst.
REQ-039 enable dropped in HEAT at cycle 3 of MIN_ON -> heater_en low after that edge, then PURGE (macro defined) or direct HOLD (macro undefined).
REQ-040 rst asserted during COOL -> all outputs 0 and state=0 after the edge; a fresh request then restarts at LEAD.

Source files
------------

// File: rtl/hvac_sequencer.sv
// hvac_sequencer: fan-lead / minimum-on / purge / lockout sequencer for a
// single heater and a single AC compressor sharing one blower.
// Optional feature macro: HVAC_FAN_PURGE_EN. When defined, every actuator run
// is followed by a fan-only PURGE phase before the HOLD lockout. When it is
// undefined, HEAT/COOL go straight to HOLD and state 4 is never entered.
module hvac_sequencer #(
  parameter int FAN_LEAD  = 4,
  parameter int MIN_ON    = 16,
  parameter int MIN_OFF   = 32,
  parameter int FAN_PURGE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       heater_on,
  input  logic       ac_on,
  output logic       heater_en,
  output logic       ac_en,
  output logic       fan_en,
  output logic       lockout,
  output logic       req_conflict,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HEAT  = 3'd2,
    COOL  = 3'd3,
    PURGE = 3'd4,
    HOLD  = 3'd5
  } state_t;

  localparam logic [15:0] LEAD_LD  = 16'(FAN_LEAD - 1);
  localparam logic [15:0] ON_LD    = 16'(MIN_ON - 1);
  localparam logic [15:0] OFF_LD   = 16'(MIN_OFF - 1);
  localparam logic [15:0] PURGE_LD = 16'(FAN_PURGE - 1);

  // Every timing parameter must fit the 16-bit down-counter and be non-zero.
  if (FAN_LEAD < 1 || FAN_LEAD > 65535 || MIN_ON < 1 || MIN_ON > 65535 ||
      MIN_OFF < 1 || MIN_OFF > 65535 || FAN_PURGE < 1 || FAN_PURGE > 65535) begin : g_param_err
    $error("hvac_sequencer: timing parameters must lie in 1..65535");
  end

  state_t      cur;
  state_t      nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [15:0] cnt_dec;
  logic        mode;      // 0 = heat run, 1 = cool run
  logic        mode_nxt;
  logic        heat_req;
  logic        cool_req;
  logic        lat_req;
  logic        cnt_zero;

  // Both requests together are treated as no request at all.
  assign heat_req = heater_on & ~ac_on;
  assign cool_req = ac_on & ~heater_on;
  // An opposite-mode request reads as the latched request being dropped.
  assign lat_req  = mode ? cool_req : heat_req;
  assign cnt_zero = (cnt == 16'd0);
  assign cnt_dec  = cnt_zero ? 16'd0 : (cnt - 16'd1);
  assign state    = cur;

  // State, counter and latched mode registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= IDLE;
      cnt  <= 16'd0;
      mode <= 1'b0;
    end else begin
      cur  <= nxt;
      cnt  <= cnt_nxt;
      mode <= mode_nxt;
    end
  end

  // Next-state, counter load/decrement and mode latch.
  always_comb begin
    nxt      = cur;
    cnt_nxt  = cnt_dec;
    mode_nxt = mode;
    case (cur)
      IDLE: begin
        if (enable && (heat_req || cool_req)) begin
          nxt      = LEAD;
          mode_nxt = cool_req;
          cnt_nxt  = LEAD_LD;
        end
      end
      LEAD: begin
        if (!enable || !lat_req) begin
          nxt = IDLE;
        end else if (cnt_zero) begin
          nxt     = mode ? COOL : HEAT;
          cnt_nxt = ON_LD;
        end
      end
      HEAT, COOL: begin
        if (!enable || (cnt_zero && !lat_req)) begin
`ifdef HVAC_FAN_PURGE_EN
          nxt     = PURGE;
          cnt_nxt = PURGE_LD;
`else
          nxt     = HOLD;
          cnt_nxt = OFF_LD;
`endif
        end
      end
      PURGE: begin
`ifdef HVAC_FAN_PURGE_EN
        if (cnt_zero) begin
          nxt     = HOLD;
          cnt_nxt = OFF_LD;
        end
`else
        // Unreachable in this build; recover to a safe idle.
        nxt     = IDLE;
        cnt_nxt = 16'd0;
`endif
      end
      HOLD: begin
        if (cnt_zero) begin
          nxt = IDLE;
        end
      end
      default: begin
        nxt     = IDLE;
        cnt_nxt = 16'd0;
      end
    endcase
  end

  // Registered Moore outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      heater_en <= 1'b0;
      ac_en     <= 1'b0;
      fan_en    <= 1'b0;
      lockout   <= 1'b0;
    end else begin
      heater_en <= (nxt == HEAT);
      ac_en     <= (nxt == COOL);
      fan_en    <= (nxt == LEAD) || (nxt == HEAT) || (nxt == COOL) || (nxt == PURGE);
      lockout   <= (nxt == HOLD);
    end
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_conflict <= 1'b0;
    end else if (heater_on && ac_on) begin
      req_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hvac_sequencer.sv
// Testbench for hvac_sequencer: a vector table, hand-written multi-cycle
// sequences and a randomized run, all checked every cycle against a
// phase/elapsed-time reference model. Honours HVAC_FAN_PURGE_EN.
module tb_hvac_sequencer;

  localparam int FAN_LEAD  = 4;
  localparam int MIN_ON    = 16;
  localparam int MIN_OFF   = 32;
  localparam int FAN_PURGE = 8;
`ifdef HVAC_FAN_PURGE_EN
  localparam int P_LEN = FAN_PURGE;
`else
  localparam int P_LEN = 0;
`endif
  localparam logic [2:0] EXIT_ST = (P_LEN > 0) ? 3'd4 : 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       heater_on = 1'b0;
  logic       ac_on = 1'b0;
  logic       heater_en;
  logic       ac_en;
  logic       fan_en;
  logic       lockout;
  logic       req_conflict;
  logic [2:0] state;

  hvac_sequencer #(
    .FAN_LEAD(FAN_LEAD), .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .FAN_PURGE(FAN_PURGE)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .heater_on(heater_on), .ac_on(ac_on),
    .heater_en(heater_en), .ac_en(ac_en), .fan_en(fan_en), .lockout(lockout),
    .req_conflict(req_conflict), .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: named phase plus cycles elapsed in that phase.
  int m_phase = 0;
  int m_age   = 0;
  bit m_mode  = 1'b0;
  bit m_conf  = 1'b0;

  typedef struct {
    bit       rst;
    bit       en;
    bit       h;
    bit       a;
    bit [2:0] st;
    bit       he;
    bit       ae;
    bit       fe;
    bit       lk;
    bit       cf;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [7:0] dut_vec();
    return {state, heater_en, ac_en, fan_en, lockout, req_conflict};
  endfunction

  // Expected outputs for a given phase: actuator per phase, fan whenever
  // the blower is running, lockout only in HOLD.
  function automatic logic [7:0] ev(input logic [2:0] s, input bit c);
    bit he, ae, fe, lk;
    he = (s == 3'd2);
    ae = (s == 3'd3);
    fe = (s == 3'd1) || (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    lk = (s == 3'd5);
    return {s, he, ae, fe, lk, c};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {state,heat,ac,fan,lock,conf}=%b_%b expected %b_%b",
               name, act[7:5], act[4:0], exp[7:5], exp[4:0]);
    end
  endtask

  task automatic model_step();
    bit hr, cr, req;
    hr  = heater_on && !ac_on;
    cr  = ac_on && !heater_on;
    req = m_mode ? cr : hr;
    if (rst) begin
      m_phase = 0; m_age = 0; m_mode = 1'b0; m_conf = 1'b0;
    end else begin
      case (m_phase)
        0: if (enable && (hr || cr)) begin m_phase = 1; m_mode = cr; m_age = 0; end
        1: begin
          if (!enable || !req) m_phase = 0;
          else if (m_age == FAN_LEAD - 1) begin m_phase = m_mode ? 3 : 2; m_age = 0; end
          else m_age++;
        end
        2, 3: begin
          if (!enable || (m_age >= MIN_ON - 1 && !req)) begin
            m_phase = (P_LEN > 0) ? 4 : 5; m_age = 0;
          end else m_age++;
        end
        4: if (m_age == FAN_PURGE - 1) begin m_phase = 5; m_age = 0; end else m_age++;
        default: if (m_age == MIN_OFF - 1) begin m_phase = 0; m_age = 0; end else m_age++;
      endcase
      if (heater_on && ac_on) m_conf = 1'b1;
    end
  endtask

  // One clock: advance the model on the edge, compare just after it.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model", dut_vec(), ev(3'(m_phase), m_conf));
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; heater_on = 1'b0; ac_on = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    //        rst en h a   st he ae fe lk cf
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    tbl[2] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[3] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 0};
    tbl[5] = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 0};
    tbl[6] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[8] = '{0, 1, 0, 1, 1, 0, 0, 1, 0, 0};
    tbl[9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

    tick();
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; enable = tbl[i].en; heater_on = tbl[i].h; ac_on = tbl[i].a;
      tick();
      chk($sformatf("vec%0d", i), dut_vec(),
          {tbl[i].st, tbl[i].he, tbl[i].ae, tbl[i].fe, tbl[i].lk, tbl[i].cf});
    end

    // Heat held, then dropped: lead, minimum on, purge, lockout, idle.
    do_reset();
    enable = 1'b1; heater_on = 1'b1;
    tick();            chk("heat_lead", dut_vec(), ev(3'd1, 1'b0));
    ticks(3);          chk("heat_lead_end", dut_vec(), ev(3'd1, 1'b0));
    tick();            chk("heat_on", dut_vec(), ev(3'd2, 1'b0));
    tick();
    heater_on = 1'b0;
    ticks(14);         chk("heat_min_on", dut_vec(), ev(3'd2, 1'b0));
    tick();            chk("heat_exit", dut_vec(), ev(EXIT_ST, 1'b0));
    ticks(P_LEN);      chk("heat_hold", dut_vec(), ev(3'd5, 1'b0));
    ticks(MIN_OFF - 1); chk("heat_hold_end", dut_vec(), ev(3'd5, 1'b0));
    tick();            chk("heat_idle", dut_vec(), ev(3'd0, 1'b0));

    // Cool run switched to heat halfway through the minimum on time.
    do_reset();
    enable = 1'b1; ac_on = 1'b1;
    tick();
    ticks(FAN_LEAD);   chk("cool_on", dut_vec(), ev(3'd3, 1'b0));
    ticks(MIN_ON / 2);
    ac_on = 1'b0; heater_on = 1'b1;
    ticks(MIN_ON / 2 - 1); chk("cool_held", dut_vec(), ev(3'd3, 1'b0));
    tick();            chk("cool_exit", dut_vec(), ev(EXIT_ST, 1'b0));
    ticks(P_LEN + MIN_OFF); chk("switch_idle", dut_vec(), ev(3'd0, 1'b0));
    tick();            chk("switch_lead", dut_vec(), ev(3'd1, 1'b0));
    ticks(FAN_LEAD);   chk("switch_heat", dut_vec(), ev(3'd2, 1'b0));

    // Enable dropped on the third cycle of heating.
    do_reset();
    enable = 1'b1; heater_on = 1'b1;
    tick();
    ticks(FAN_LEAD);   chk("en_heat", dut_vec(), ev(3'd2, 1'b0));
    ticks(2);
    enable = 1'b0;
    tick();            chk("en_drop", dut_vec(), ev(EXIT_ST, 1'b0));
    ticks(P_LEN);      chk("en_hold", dut_vec(), ev(3'd5, 1'b0));
    ticks(MIN_OFF);    chk("en_idle", dut_vec(), ev(3'd0, 1'b0));
    tick();            chk("en_stay_idle", dut_vec(), ev(3'd0, 1'b0));

    // Reset in the middle of a cool run, then a fresh start.
    do_reset();
    enable = 1'b1; ac_on = 1'b1;
    tick();
    ticks(FAN_LEAD + 3); chk("rst_cool", dut_vec(), ev(3'd3, 1'b0));
    rst = 1'b1;
    tick();            chk("rst_mid", dut_vec(), ev(3'd0, 1'b0));
    rst = 1'b0;
    tick();            chk("rst_restart", dut_vec(), ev(3'd1, 1'b0));

    // Randomized segments of held inputs, checked every cycle by the model.
    for (int s = 0; s < 150; s++) begin
      int dur;
      dur = $urandom_range(1, 40);
      rst = ($urandom_range(0, 99) < 3);
      if (rst) dur = 1;
      enable = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 7))
        0, 1, 2: begin heater_on = 1'b1; ac_on = 1'b0; end
        3, 4, 5: begin heater_on = 1'b0; ac_on = 1'b1; end
        6:       begin heater_on = 1'b0; ac_on = 1'b0; end
        default: begin heater_on = 1'b1; ac_on = 1'b1; end
      endcase
      ticks(dur);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
